hv_bundler: RTL

Downstream accumulation stage for the compute core. Consumes the `store`/`core_result`/`last` stream the core produces. Keeps a per-bit popcount of every stored hypervector and, on `last`, thresholds the counts by majority into one binary hypervector. It then drains the bundled vector to the DMA side as 32-bit words over a valid/ready handshake.

---
 rtl/hv_bundler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/hv_bundler.sv
// hv_bundler: per-bit popcount of stored hypervectors, majority threshold on `last`,
// then drain as 32-bit words. Optional macro HV_BUNDLER_TIEBREAK_EN resolves ties to the newest vector.
module hv_bundler #(
    parameter int DIM = 1023,
    parameter int CW  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    input  logic           store,
    input  logic [DIM:0]   core_result,
    input  logic           last,
    input  logic           out_ready,
    output logic           out_valid,
    output logic [31:0]    out_data,
    output logic           out_last,
    output logic           busy,
    output logic           err
);

    localparam int VW = DIM + 1;
    localparam int WN = VW / 32;
    localparam int WW = (WN > 1) ? $clog2(WN) : 1;
    localparam logic [CW-1:0] N_MAX = {CW{1'b1}};

    typedef enum logic [1:0] {ACCUM, THRESH, DRAIN} state_t;

    state_t          state_reg;
    logic [CW-1:0]   n_reg;
    logic [WW-1:0]   w_reg;
    logic [VW-1:0]   res_reg;
    logic [VW-1:0]   res_next;
    logic [VW-1:0]   tie_vec;
    logic            out_valid_reg;
    logic            out_last_reg;
    logic            busy_reg;
    logic            err_reg;

    logic            store_ok;
    logic            final_hs;
    logic            cnt_clr;
    logic            err_set;

    // A store is accepted only while accumulating and before the vector count saturates.
    assign store_ok = run && store && (state_reg == ACCUM) && (n_reg != N_MAX);
    assign final_hs = (state_reg == DRAIN) && out_valid_reg && out_ready && out_last_reg;
    assign cnt_clr  = !run || final_hs;
    assign err_set  = (store && (state_reg == ACCUM) && (n_reg == N_MAX)) ||
                      ((store || last) && (state_reg != ACCUM));

`ifdef HV_BUNDLER_TIEBREAK_EN
    logic [VW-1:0] last_vec_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_vec_reg <= '0;
        end else if (cnt_clr) begin
            last_vec_reg <= '0;
        end else if (store_ok) begin
            last_vec_reg <= core_result;
        end
    end

    assign tie_vec = last_vec_reg;
`else
    assign tie_vec = '0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < VW; gi++) begin : g_bit
            logic [CW-1:0] cnt_reg;
            logic [CW:0]   twice_cnt;
            logic [CW:0]   n_ext;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (cnt_clr) begin
                    cnt_reg <= '0;
                end else if (store_ok && core_result[gi]) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            // Majority at CW+1 bits so 2*cnt never wraps.
            assign twice_cnt    = {cnt_reg, 1'b0};
            assign n_ext        = {1'b0, n_reg};
            assign res_next[gi] = (twice_cnt > n_ext) || ((twice_cnt == n_ext) && tie_vec[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ACCUM;
            n_reg         <= '0;
            w_reg         <= '0;
            res_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else if (!run) begin
            state_reg     <= ACCUM;
            n_reg         <= '0;
            w_reg         <= '0;
            res_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            if (err_set) begin
                err_reg <= 1'b1;
            end
            case (state_reg)
                ACCUM: begin
                    if (store_ok) begin
                        n_reg <= n_reg + 1'b1;
                    end
                    if (last) begin
                        state_reg <= THRESH;
                        busy_reg  <= 1'b1;
                    end
                end
                THRESH: begin
                    res_reg       <= res_next;
                    w_reg         <= '0;
                    out_valid_reg <= 1'b1;
                    out_last_reg  <= (WN == 1);
                    state_reg     <= DRAIN;
                end
                DRAIN: begin
                    if (out_ready) begin
                        // The word on out_data is always the low slice; shift to present the next one.
                        res_reg <= res_reg >> 32;
                        if (out_last_reg) begin
                            state_reg     <= ACCUM;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            busy_reg      <= 1'b0;
                            n_reg         <= '0;
                            w_reg         <= '0;
                        end else begin
                            w_reg        <= w_reg + 1'b1;
                            out_last_reg <= ((w_reg + 1'b1) == WW'(WN - 1));
                        end
                    end
                end
                default: begin
                    state_reg <= ACCUM;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = res_reg[31:0];
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;
    assign err       = err_reg;

endmodule
